// File: rtl/line_sram_ctrl.sv
// One-line delay for the bicubic vertical taps: pairs each pixel with the previous line's pixel at the same column.
// Optional macro LINE_FIRST_REPLICATE_EN: replicate the current pixel as m_prev on first-line pixels.
module line_sram_ctrl #(
  parameter int DATA_WIDTH = 24,
  parameter int LINE_W     = 960,
  parameter int ADDR_WIDTH = $clog2(LINE_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_sof,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_cur,
  output logic [DATA_WIDTH-1:0] m_prev,
  output logic [ADDR_WIDTH-1:0] m_col,
  output logic                  m_first_line,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_cs_n,
  output logic                  sram_wr_en,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(LINE_W - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] col_cnt_q, col_cnt_d;
  logic                  first_line_q, first_line_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic                  fl_q, fl_d;
  logic [DATA_WIDTH-1:0] cur_q, cur_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;

  logic                  acc;
  logic                  last_col;
  logic [ADDR_WIDTH-1:0] col_adv;
  logic                  fl_adv;
  logic [ADDR_WIDTH-1:0] base_col;
  logic                  base_fl;
  logic [ADDR_WIDTH-1:0] acol;
  logic [DATA_WIDTH-1:0] first_prev;

  // In HOLD the next accept lands in the column after the pair being released,
  // so the column/first-line bases are taken from the advance path, not the counter.
  assign last_col = (col_q == LAST_COL);
  assign col_adv  = last_col ? '0 : col_q + ADDR_WIDTH'(1);
  assign fl_adv   = last_col ? 1'b0 : fl_q;
  assign base_col = (state_q == HOLD) ? col_adv : col_cnt_q;
  assign base_fl  = (state_q == HOLD) ? fl_adv : first_line_q;
  assign acol     = s_sof ? '0 : base_col;

  assign s_ready = ~rst & ((state_q == IDLE) | ((state_q == HOLD) & m_ready));
  assign acc     = s_valid & s_ready;

`ifdef LINE_FIRST_REPLICATE_EN
  assign first_prev = cur_q;
`else
  assign first_prev = '0;
`endif

  always_comb begin
    state_d      = state_q;
    col_cnt_d    = col_cnt_q;
    first_line_d = first_line_q;
    col_d        = col_q;
    fl_d         = fl_q;
    cur_d        = cur_q;
    prev_d       = prev_q;
    sram_cs_n    = 1'b1;
    sram_wr_en   = 1'b0;
    sram_addr    = '0;
    sram_wdata   = '0;

    case (state_q)
      IDLE: begin
        if (acc) begin
          sram_cs_n = 1'b0;
          sram_addr = acol;
          cur_d     = s_data;
          col_d     = acol;
          fl_d      = s_sof | base_fl;
          state_d   = WRITE;
        end
      end

      WRITE: begin
        // Stale SRAM contents on a first line are never exposed.
        prev_d     = fl_q ? first_prev : sram_rdata;
        sram_cs_n  = 1'b0;
        sram_wr_en = 1'b1;
        sram_addr  = col_q;
        sram_wdata = cur_q;
        state_d    = HOLD;
      end

      HOLD: begin
        if (m_ready) begin
          col_cnt_d    = col_adv;
          first_line_d = fl_adv;
          if (acc) begin
            sram_cs_n = 1'b0;
            sram_addr = acol;
            cur_d     = s_data;
            col_d     = acol;
            fl_d      = s_sof | base_fl;
            state_d   = WRITE;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      col_cnt_q    <= '0;
      first_line_q <= 1'b1;
      col_q        <= '0;
      fl_q         <= 1'b1;
      cur_q        <= '0;
      prev_q       <= '0;
    end else begin
      state_q      <= state_d;
      col_cnt_q    <= col_cnt_d;
      first_line_q <= first_line_d;
      col_q        <= col_d;
      fl_q         <= fl_d;
      cur_q        <= cur_d;
      prev_q       <= prev_d;
    end
  end

  assign m_valid      = (state_q == HOLD);
  assign m_cur        = cur_q;
  assign m_prev       = prev_q;
  assign m_col        = col_q;
  assign m_first_line = fl_q;

endmodule

// File: tb/tb_line_sram_ctrl.sv
// Directed bench for line_sram_ctrl with a 4-deep line and a behavioural registered-read SRAM.
module tb_line_sram_ctrl;
  localparam int DW = 24;
  localparam int LW = 4;
  localparam int AW = 2;
`ifdef LINE_FIRST_REPLICATE_EN
  localparam logic [31:0] FPMASK = 32'h00FF_FFFF;
`else
  localparam logic [31:0] FPMASK = 32'h0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_sof;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready, m_first_line;
  logic [DW-1:0] m_cur, m_prev;
  logic [AW-1:0] m_col;
  logic [AW-1:0] sram_addr;
  logic          sram_cs_n, sram_wr_en;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic [DW-1:0] mem [LW];
  logic          fill;

  int vecs = 0;
  int errs = 0;

  line_sram_ctrl #(.DATA_WIDTH(DW), .LINE_W(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_cur(m_cur), .m_prev(m_prev),
    .m_col(m_col), .m_first_line(m_first_line),
    .sram_addr(sram_addr), .sram_cs_n(sram_cs_n), .sram_wr_en(sram_wr_en),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < LW; i++) mem[i] <= 24'hABCDEF;
      sram_rdata <= 24'h0;
    end else if (!sram_cs_n) begin
      if (sram_wr_en) mem[sram_addr] <= sram_wdata;
      else            sram_rdata <= mem[sram_addr];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fp(input logic [31:0] c);
    return c & FPMASK;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_mvalid"}, 32'(m_valid), 0);
    chk({tag, "_mcur"}, 32'(m_cur), 0);
    chk({tag, "_mprev"}, 32'(m_prev), 0);
    chk({tag, "_mcol"}, 32'(m_col), 0);
    chk({tag, "_mfl"}, 32'(m_first_line), 1);
    chk({tag, "_sready"}, 32'(s_ready), 0);
    chk({tag, "_csn"}, 32'(sram_cs_n), 1);
    chk({tag, "_wren"}, 32'(sram_wr_en), 0);
    chk({tag, "_addr"}, 32'(sram_addr), 0);
    chk({tag, "_wdata"}, 32'(sram_wdata), 0);
  endtask

  task automatic chk_pair(input logic [31:0] c, input logic [31:0] p,
                          input logic [31:0] col, input logic [31:0] fl);
    chk("pair_mvalid", 32'(m_valid), 1);
    chk("pair_mcur", 32'(m_cur), c);
    chk("pair_mprev", 32'(m_prev), p);
    chk("pair_mcol", 32'(m_col), col);
    chk("pair_mfl", 32'(m_first_line), fl);
  endtask

  // Accept cycle (read) then WRITE cycle; optionally checks the pair released in the accept cycle.
  task automatic pix(input logic [31:0] d, input logic sof, input logic [31:0] addr,
                     input logic pv, input logic [31:0] pc, input logic [31:0] pp,
                     input logic [31:0] pcol, input logic [31:0] pfl);
    s_valid = 1'b1;
    s_data  = d[DW-1:0];
    s_sof   = sof;
    #1;
    if (pv) chk_pair(pc, pp, pcol, pfl);
    else    chk("acc_mvalid", 32'(m_valid), 0);
    chk("acc_sready", 32'(s_ready), 1);
    chk("rd_csn", 32'(sram_cs_n), 0);
    chk("rd_wren", 32'(sram_wr_en), 0);
    chk("rd_addr", 32'(sram_addr), addr);
    tick();
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_data  = '0;
    #1;
    chk("wr_sready", 32'(s_ready), 0);
    chk("wr_mvalid", 32'(m_valid), 0);
    chk("wr_csn", 32'(sram_cs_n), 0);
    chk("wr_wren", 32'(sram_wr_en), 1);
    chk("wr_addr", 32'(sram_addr), addr);
    chk("wr_wdata", 32'(sram_wdata), d);
    tick();
  endtask

  task automatic drain(input logic [31:0] c, input logic [31:0] p,
                       input logic [31:0] col, input logic [31:0] fl);
    s_valid = 1'b0;
    #1;
    chk_pair(c, p, col, fl);
    tick();
    chk("drain_mvalid", 32'(m_valid), 0);
    chk("drain_sready", 32'(s_ready), 1);
    chk("drain_csn", 32'(sram_cs_n), 1);
  endtask

  initial begin
    rst = 1'b1; fill = 1'b1;
    s_valid = 1'b0; s_sof = 1'b0; s_data = '0; m_ready = 1'b0;
    #2;
    chk_reset("rst");
    tick();
    tick();
    fill = 1'b0;
    rst  = 1'b0;
    m_ready = 1'b1;

    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_csn", 32'(sram_cs_n), 1);
      chk("idle_mvalid", 32'(m_valid), 0);
      chk("idle_sready", 32'(s_ready), 1);
      tick();
    end

    // Line 1 (first line), then line 2
    pix(1, 1'b1, 0, 1'b0, 0, 0, 0, 0);
    pix(2, 1'b0, 1, 1'b1, 1, fp(1), 0, 1);
    pix(3, 1'b0, 2, 1'b1, 2, fp(2), 1, 1);
    pix(4, 1'b0, 3, 1'b1, 3, fp(3), 2, 1);
    pix(5, 1'b0, 0, 1'b1, 4, fp(4), 3, 1);
    pix(6, 1'b0, 1, 1'b1, 5, 1, 0, 0);
    pix(7, 1'b0, 2, 1'b1, 6, 2, 1, 0);
    pix(8, 1'b0, 3, 1'b1, 7, 3, 2, 0);

    // Backpressure on pair 8 with pixel 9 waiting
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 24'd9;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_pair(8, 4, 3, 0);
      chk("bp_sready", 32'(s_ready), 0);
      chk("bp_csn", 32'(sram_cs_n), 1);
      tick();
    end
    m_ready = 1'b1;
    pix(9, 1'b0, 0, 1'b1, 8, 4, 3, 0);
    pix(10, 1'b0, 1, 1'b1, 9, 5, 0, 0);

    // Mid-line start of frame at column 2
    pix(11, 1'b1, 0, 1'b1, 10, 6, 1, 0);
    drain(11, fp(11), 0, 1);

    // Reset asserted during WRITE
    s_valid = 1'b1;
    s_data  = 24'd12;
    #1;
    chk("r12_sready", 32'(s_ready), 1);
    chk("r12_addr", 32'(sram_addr), 1);
    tick();
    s_valid = 1'b0;
    #1;
    chk("r12_wren", 32'(sram_wr_en), 1);
    rst = 1'b1;
    #1;
    chk_reset("rst_wr");
    tick();
    rst = 1'b0;
    tick();
    pix(13, 1'b0, 0, 1'b0, 0, 0, 0, 0);
    drain(13, fp(13), 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/line_sram_ctrl.md
Name: line_sram_ctrl

Overview:
- Initiator side of the single-port line SRAM (24-bit, 960-deep, 1-cycle registered read, active-low chip select) in the bicubic v2 datapath.
- Accepts a raster pixel stream. For each pixel it reads the previous line's pixel at the same column, then overwrites that location with the current pixel.
- Emits {previous-line, current} pixel pairs downstream over valid/ready. This is the one-line delay the bicubic vertical taps use.

Parameters:
DATA_WIDTH, 24, pixel width (RGB888), equal to the SRAM data width
LINE_W, 960, pixels per line, equal to the SRAM depth
ADDR_WIDTH, $clog2(LINE_W), SRAM address and column counter width

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
s_valid  in  1  input pixel valid
s_ready  out  1  input pixel accepted when s_valid & s_ready
s_sof  in  1  start of frame, qualified with s_valid
s_data  in  DATA_WIDTH  input pixel
m_valid  out  1  output pair valid
m_ready  in  1  downstream ready
m_cur  out  DATA_WIDTH  current-line pixel
m_prev  out  DATA_WIDTH  previous-line pixel, same column
m_col  out  ADDR_WIDTH  column of the pair
m_first_line  out  1  pair belongs to the first line of the frame
sram_addr  out  ADDR_WIDTH  SRAM address
sram_cs_n  out  1  SRAM chip select, active low
sram_wr_en  out  1  SRAM write enable
sram_wdata  out  DATA_WIDTH  SRAM write data
sram_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after a read

Behaviour:
- Reset (async, rst=1):
  - State IDLE; col=0; first_line=1; cur_q=0; prev_q=0.
  - m_valid=0, m_cur=0, m_prev=0, m_col=0, m_first_line=1.
  - s_ready=0 while rst is asserted.
  - sram_cs_n=1, sram_wr_en=0, sram_addr=0, sram_wdata=0.
- sram_* outputs are combinational decodes of state and registers. The SRAM registers them at the next edge.
- Accept: acc = s_valid & s_ready. s_ready = (state==IDLE) | (state==HOLD & m_ready).
- Effective column on accept: acol = s_sof ? 0 : col.
- IDLE:
  - On acc: drive read (cs_n=0, wr_en=0, addr=acol).
  - Capture s_data->cur_q, acol->col_q, (s_sof | first_line)->fl_q.
  - Go to WRITE.
  - With no accept: cs_n=1.
- WRITE (exactly 1 cycle):
  - sram_rdata holds the read result. Latch prev_q = fl_q ? 0 : sram_rdata.
  - Drive write (cs_n=0, wr_en=1, addr=col_q, wdata=cur_q).
  - Go to HOLD and assert m_valid from the next cycle.
  - s_ready=0 in WRITE.
- HOLD:
  - m_valid=1. m_cur, m_prev, m_col, m_first_line are stable until the handshake.
  - On m_ready: advance col (wrap at LINE_W-1 to 0; wrap clears first_line; s_sof forces first_line=1).
  - If acc occurs in the same cycle, issue the next read immediately and go to WRITE. Otherwise go to IDLE; m_valid=0.
- Throughput: 2 cycles/pixel sustained. Latency: accept to m_valid is 2 cycles.
- s_sof mid-line: column resets to 0 and the line is treated as first. Stale SRAM contents are masked to 0.
- Reset mid-operation: any in-flight pair is dropped. SRAM contents are not cleared; first_line=1 masks them.
- Each column is read before it is written, so m_prev always returns the old value (read-before-write).

Optional Feature:
LINE_FIRST_REPLICATE_EN
- Defined: on first-line pixels, prev_q = cur_q (vertical border replication for bicubic edge taps).
- Undefined: first-line m_prev = 0.
- All other behaviour is identical.

Test Plan:
- Reset then idle, LINE_W=4 -> all outputs at reset values; sram_cs_n=1 held; no SRAM access.
- Frame of 2 lines, pixels 0x000001..0x000008, s_sof on the first, m_ready=1 -> line 1 pairs have m_prev=0, m_first_line=1. Line 2 pairs have m_prev=0x000001..0x000004, m_cur=0x000005..0x000008, m_col=0..3. One pair every 2 cycles.
- Backpressure: m_ready=0 for 5 cycles while in HOLD -> m_* stable, s_ready=0, no SRAM access. Release -> next pixel accepted in the same cycle.
- SRAM sequencing: for the pixel at col 2 -> cycle N read addr 2 (wr_en=0); N+1 write addr 2 with wdata=pixel; m_valid at N+2.
- s_sof asserted at col 2 of line 2 -> m_col=0, m_first_line=1, m_prev=0 (=m_cur with LINE_FIRST_REPLICATE_EN).
- rst pulsed while in WRITE -> outputs return to reset values asynchronously. The next pixel is treated as first line with m_prev=0.
